// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer and instruction memory.
// Combinational wiring only, no latency.
// Memory stalls a fetch by holding imem_ack low while imem_req is high.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] Instr_in;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  Instr_in
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output Instr_in
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches, holds one instruction for a single execute cycle, then redirects.
// Latency: minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC).
// Backpressure: FETCH holds all state until imem_ack; a misaligned jr target parks the FSM in HALT.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Branch_deci,
  input  logic                 Jump,
  input  logic                 Jump_reg,
  input  logic [31:0]          Imm_ext,
  input  logic [25:0]          Jump_index,
  input  logic [31:0]          Rs_data,
  pc_sequencer_if.master       imem,
  output logic [31:0]          Instr,
  output logic                 Instr_valid,
  output logic [31:0]          PC_out,
  output logic [31:0]          PC_plus4,
  output logic                 misaligned_err,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic                 req_q, req_d;
  logic [31:0]          instr_q, instr_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign jr_misaligned = Jump_reg && (Rs_data[1:0] != 2'b00);

  // Next-PC select: jr beats j/jal, which beats a taken branch, which beats sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump_reg) begin
      next_pc = Rs_data;
    end else if (Jump) begin
      next_pc = {pc_plus4[31:28], Jump_index, 2'b00};
    end else if (Branch_deci) begin
      next_pc = pc_plus4 + (Imm_ext << 2);
    end
  end

  // FSM next state and register updates; everything holds unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.Instr_in;
          vld_d   = 1'b1;
          req_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        vld_d = 1'b0;
        if (jr_misaligned) begin
          // Bad jr target: keep the faulting PC visible and stop fetching.
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = HALT;
        end else begin
          pc_d    = next_pc;
          req_d   = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = FETCH;
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 32'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Instr          = instr_q;
  assign Instr_valid    = vld_q;
  assign PC_out         = pc_q;
  assign PC_plus4       = pc_plus4;
  assign misaligned_err = err_q;
  assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed fetch/execute sequences with hand-computed PCs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Branch_deci, Jump, Jump_reg;
  logic [31:0] Imm_ext, Rs_data;
  logic [25:0] Jump_index;
  logic [31:0] Instr, PC_out, PC_plus4;
  logic        Instr_valid, misaligned_err;
  logic [3:0]  retired_cnt;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Branch_deci    (Branch_deci),
    .Jump           (Jump),
    .Jump_reg       (Jump_reg),
    .Imm_ext        (Imm_ext),
    .Jump_index     (Jump_index),
    .Rs_data        (Rs_data),
    .imem           (bus.master),
    .Instr          (Instr),
    .Instr_valid    (Instr_valid),
    .PC_out         (PC_out),
    .PC_plus4       (PC_plus4),
    .misaligned_err (misaligned_err),
    .retired_cnt    (retired_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every execute cycle must match the oldest acked fetch.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && Instr_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_exec", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exec_pc", PC_out, e.pc);
        chk("exec_instr", Instr, e.iw);
        chk("exec_req_low", {31'd0, bus.imem_req}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Branch_deci = 1'b0;
    Jump        = 1'b0;
    Jump_reg    = 1'b0;
    Imm_ext     = 32'hDEAD_BEEF;
    Jump_index  = 26'h3FF_FFFF;
    Rs_data     = 32'hFFFF_FFFF;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.imem_req !== 1'b1) chk("fetch_timeout", 32'd1, 32'd0);
  endtask

  // One instruction: ack its fetch at once, then drive the execute-cycle controls.
  task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] iw,
                           input logic bd, input logic j, input logic jr,
                           input logic [31:0] imm, input logic [25:0] idx,
                           input logic [31:0] rs);
    wait_fetch();
    chk("fetch_addr", bus.imem_addr, exp_pc);
    sb_q.push_back('{pc: exp_pc, iw: iw});
    bus.imem_ack = 1'b1;
    bus.Instr_in = iw;
    tick();
    bus.imem_ack = 1'b0;
    bus.Instr_in = 32'hBAD0_BAD0;
    Branch_deci  = bd;
    Jump         = j;
    Jump_reg     = jr;
    Imm_ext      = imm;
    Jump_index   = idx;
    Rs_data      = rs;
    chk("vld_pulse", {31'd0, Instr_valid}, 32'd1);
    tick();
    clear_ctrl();
    chk("vld_drop", {31'd0, Instr_valid}, 32'd0);
  endtask

  task automatic seq_instr(input logic [31:0] exp_pc, input logic [31:0] iw);
    run_instr(exp_pc, iw, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state();
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_vld", {31'd0, Instr_valid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_err", {31'd0, misaligned_err}, 32'd0);
    chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.imem_ack = 1'b0;
    bus.Instr_in = 32'h0;
    clear_ctrl();
    tick();
    tick();
    rst_n = 1'b1;
    chk_reset_state();

    // Sequential fetches 0x0, 0x4, 0x8; the third is a jr (with j and branch) to 0x100.
    seq_instr(32'h0000_0000, 32'h1111_0000);
    seq_instr(32'h0000_0004, 32'h1111_0004);
    chk("cnt_after2", {28'd0, retired_cnt}, 32'd2);
    run_instr(32'h0000_0008, 32'h1111_0008, 1'b1, 1'b1, 1'b1, 32'd5, 26'h3FF_FFFF, 32'h0000_0100);
    chk("cnt_after3", {28'd0, retired_cnt}, 32'd3);

    // Backward branch: 0x104 - 0x10 = 0xF4.
    run_instr(32'h0000_0100, 32'h2222_0100, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 26'd0, 32'd0);
    run_instr(32'h0000_00F4, 32'h2222_00F4, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h0000_0100);
    // Forward branch: 0x104 + 0xC = 0x110.
    run_instr(32'h0000_0100, 32'h2222_0101, 1'b1, 1'b0, 1'b0, 32'd3, 26'd0, 32'd0);
    run_instr(32'h0000_0110, 32'h2222_0110, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h1000_0008);
    // Jump keeps PC+4 upper nibble.
    run_instr(32'h1000_0008, 32'h3333_0008, 1'b0, 1'b1, 1'b0, 32'd0, 26'h000_0040, 32'd0);
    // Jump beats a taken branch.
    run_instr(32'h1000_0100, 32'h3333_0100, 1'b1, 1'b1, 1'b0, 32'h10, 26'h000_0080, 32'd0);
    // jr beats j.
    run_instr(32'h1000_0200, 32'h3333_0200, 1'b0, 1'b1, 1'b1, 32'd0, 26'h000_0000, 32'h0000_0200);
    seq_instr(32'h0000_0200, 32'h4444_0200);
    chk("cnt_before_halt", {28'd0, retired_cnt}, 32'd11);

    // Misaligned jr: halt with PC, count frozen; stray acks ignored.
    run_instr(32'h0000_0204, 32'h5555_0204, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h0000_0202);
    bus.imem_ack = 1'b1;
    bus.Instr_in = 32'h6666_6666;
    Jump_reg     = 1'b1;
    Rs_data      = 32'h0000_0400;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_err", {31'd0, misaligned_err}, 32'd1);
      chk("halt_pc", PC_out, 32'h0000_0204);
      chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_vld", {31'd0, Instr_valid}, 32'd0);
    end
    chk("halt_cnt", {28'd0, retired_cnt}, 32'd11);
    bus.imem_ack = 1'b0;
    clear_ctrl();
    do_reset();
    chk_reset_state();

    // Fetch stall: request and address hold while ack is low.
    wait_fetch();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h0);
      chk("stall_vld", {31'd0, Instr_valid}, 32'd0);
      tick();
    end
    // Ack coinciding with reset is dropped.
    bus.imem_ack = 1'b1;
    bus.Instr_in = 32'h7777_7777;
    rst_n        = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    rst_n        = 1'b1;
    chk_reset_state();

    // 17 sequential instructions wrap the 4-bit retire counter to 1.
    for (int i = 0; i < 17; i++) begin
      seq_instr(32'(i * 4), 32'hA000_0000 + 32'(i));
      if (i == 15) chk("cnt_wrap0", {28'd0, retired_cnt}, 32'd0);
    end
    chk("cnt_wrap1", {28'd0, retired_cnt}, 32'd1);
    chk("final_pc", PC_out, 32'h0000_0044);

    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
